// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM: fetches a word, holds it for its execution time, halts on HALT_WORD
module instr_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic        instr_vld,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [3:0]  cnt_q;
  logic        vld_q;
  logic        halted_q;

  // Remaining EXEC cycles after the first: vector load/store run 16 cycles, all else 1.
  function automatic logic [3:0] exec_cnt(input logic [15:0] word);
    return (word[15:12] == 4'b0100 || word[15:12] == 4'b0101) ? 4'd15 : 4'd0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      cnt_q    <= 4'd0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= FETCH;
        end
        FETCH: begin
          if (mem_rdy) begin
            instr_q <= mem_data;
            if (mem_data == HALT_WORD) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              pc_q    <= pc_q + 16'd1;
              cnt_q   <= exec_cnt(mem_data);
              vld_q   <= 1'b1;
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          if (!stall) begin
            if (cnt_q == 4'd0) begin
              vld_q   <= 1'b0;
              state_q <= FETCH;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd    = (state_q == FETCH);
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instr_vld = vld_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a randomized memory responder
module tb_instr_fetch;

  localparam logic [15:0] RPC  = 16'hFFFE;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n, start, stall, mem_rd, mem_rdy, instr_vld, halted;
  logic [15:0] mem_addr, mem_data, instr, pc;

  instr_fetch #(.RESET_PC(RPC), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_data(mem_data),
    .instr(instr), .instr_vld(instr_vld), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] data; int delay;} fetch_t;

  fetch_t      forced[$];
  logic [15:0] exp_q[$];
  int          errors = 0, checks = 0;
  int          done_cnt = 0, last_len = 0;
  logic        resp_en = 1'b0, inj_rdy = 1'b0, stall_en = 1'b0, stall_force = 1'b0;
  logic        start_req = 1'b0, start_rand = 1'b0;
  logic [15:0] inj_data = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int          r;
    w = 16'($urandom);
    r = $urandom_range(0, 3);
    if (r == 0) w[15:12] = 4'b0100;
    else if (r == 1) w[15:12] = 4'b0101;
    if (w == HALT) w = 16'hFFFE;
    return w;
  endfunction

  // Memory responder: answers each read request after a random or forced delay.
  initial begin : responder
    logic        pending;
    int          wait_n;
    logic [15:0] cur;
    fetch_t      f;
    pending = 1'b0; wait_n = 0; cur = 16'h0;
    mem_rdy = 1'b0; mem_data = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !resp_en) begin
        pending  = 1'b0;
        mem_rdy  = inj_rdy;
        mem_data = inj_data;
      end else if (mem_rd) begin
        if (!pending) begin
          pending = 1'b1;
          if (forced.size() > 0) begin
            f = forced.pop_front();
            wait_n = f.delay;
            cur = f.data;
          end else begin
            wait_n = $urandom_range(0, 3);
            cur = rand_word();
          end
        end
        if (wait_n == 0) begin
          mem_rdy = 1'b1;
          mem_data = cur;
          exp_q.push_back(cur);
        end else begin
          wait_n--;
          mem_rdy = 1'b0;
          mem_data = 16'($urandom);
        end
      end else begin
        pending  = 1'b0;
        mem_rdy  = 1'($urandom);
        mem_data = 16'($urandom);
      end
    end
  end

  initial begin : drive_ctl
    stall = 1'b0; start = 1'b0;
    forever begin
      @(posedge clk); #1;
      stall = stall_en ? ($urandom_range(0, 3) == 0) : stall_force;
      start = start_rand ? 1'($urandom) : start_req;
    end
  end

  // Monitor: reference model tracks pc/instr and consumes expected words per fetch.
  initial begin : monitor
    logic        in_burst, halt_seen;
    logic [15:0] model_pc, model_instr, cur;
    int          nonstall, need, blen;
    in_burst = 1'b0; halt_seen = 1'b0; model_pc = RPC; model_instr = 16'h0;
    nonstall = 0; need = 0; blen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        in_burst = 1'b0; halt_seen = 1'b0; model_pc = RPC; model_instr = 16'h0;
      end else begin
        if (mem_rd) begin
          chk("fetch_addr", 32'(mem_addr), 32'(model_pc));
          chk("fetch_pc", 32'(pc), 32'(model_pc));
          chk("fetch_instr_hold", 32'(instr), 32'(model_instr));
          chk("fetch_vld_low", 32'(instr_vld), 0);
        end
        if (instr_vld) begin
          if (!in_burst) begin
            if (exp_q.size() == 0) begin
              chk("exp_available", 0, 1);
              cur = instr;
            end else begin
              cur = exp_q.pop_front();
            end
            in_burst = 1'b1; nonstall = 0; blen = 0;
            need = (cur[15:12] == 4'h4 || cur[15:12] == 4'h5) ? 16 : 1;
            model_pc = model_pc + 16'd1;
            model_instr = cur;
          end
          chk("exec_instr", 32'(instr), 32'(model_instr));
          chk("exec_pc", 32'(pc), 32'(model_pc));
          chk("exec_no_rd", 32'(mem_rd), 0);
          blen++;
          if (!stall) nonstall++;
        end else if (in_burst) begin
          chk("exec_len", nonstall, need);
          in_burst = 1'b0;
          last_len = blen;
          done_cnt++;
        end
        if (halted && !halt_seen) begin
          halt_seen = 1'b1;
          if (exp_q.size() == 0) chk("halt_exp_available", 0, 1);
          else begin
            cur = exp_q.pop_front();
            chk("halt_instr", 32'(instr), 32'(cur));
            chk("halt_is_word", 32'(cur == HALT), 1);
          end
          chk("halt_pc", 32'(pc), 32'(model_pc));
        end
        if (halt_seen) begin
          chk("halt_sticky", 32'(halted), 1);
          chk("halt_no_rd", 32'(mem_rd), 0);
          chk("halt_no_vld", 32'(instr_vld), 0);
        end
      end
    end
  end

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(posedge clk); n++;
    end
    #1;
    chk("wait_done", 32'(done_cnt >= target), 1);
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    @(posedge clk); @(posedge clk);
    start_req = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    inj_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inj_data = 16'($urandom);
      @(posedge clk); #2;
      chk({tag, "_rd"}, 32'(mem_rd), 0);
      chk({tag, "_vld"}, 32'(instr_vld), 0);
      chk({tag, "_pc"}, 32'(pc), 32'(RPC));
      chk({tag, "_instr"}, 32'(instr), 0);
    end
    inj_rdy = 1'b0;
  endtask

  initial begin : directed
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_vld", 32'(instr_vld), 0);
    chk("rst_pc", 32'(pc), 32'(RPC));
    chk("rst_instr", 32'(instr), 0);
    chk("rst_halted", 32'(halted), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_checks("idle");

    forced.push_back('{16'h0A48, 1});
    forced.push_back('{16'h4285, 0});
    forced.push_back('{16'h5123, 5});
    forced.push_back('{16'h4001, 0});
    resp_en = 1'b1;
    pulse_start();
    wait_done(2, 200);
    chk("pc_wrap", 32'(pc), 0);
    wait_done(3, 200);
    n = 0;
    while (!instr_vld && n < 50) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    stall_force = 1'b1;
    repeat (3) @(posedge clk);
    stall_force = 1'b0;
    wait_done(4, 200);
    chk("vld_stall_len", last_len, 19);

    stall_en = 1'b1; start_rand = 1'b1;
    wait_done(44, 8000);

    n = 0;
    while (!instr_vld && n < 100) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(instr_vld), 0);
    chk("async_rst_rd", 32'(mem_rd), 0);
    chk("async_rst_pc", 32'(pc), 32'(RPC));
    chk("async_rst_instr", 32'(instr), 0);
    chk("async_rst_halted", 32'(halted), 0);
    stall_en = 1'b0; start_rand = 1'b0; resp_en = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_checks("post_rst");

    forced.push_back('{HALT, 2});
    resp_en = 1'b1;
    pulse_start();
    n = 0;
    while (!halted && n < 30) begin @(posedge clk); #1; n++; end
    chk("halt_reached", 32'(halted), 1);
    chk("halt_pc_keep", 32'(pc), 32'(RPC));
    pulse_start();
    repeat (5) begin
      @(posedge clk); #2;
      chk("halt_ignore_start", 32'(mem_rd), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
